cr_prefix_ib_arb: RTL and testbench
===================================

# cr_prefix_ib_arb

Parametrised N-channel ingress arbiter for the prefix datapath. It merges `N_CH` independent AXI4-stream sources into the single `prefix_ib_in` port of one prefix instance. Arbitration is frame-level round-robin: a grant is held until `tlast` and frames are never interleaved. A 2-entry output skid buffer decouples downstream backpressure from the input ready paths. An optional frame-length watchdog raises a sticky per-channel error and an interrupt.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels, 2..16.
- `MAX_BEATS`, default 1024: beats allowed in one frame before the watchdog fires, 2..65535.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ib_in[N_CH]` in axi4s_dp_bus_t: per-channel input beats; `tvalid`/`tlast` interpreted, all other fields carried unchanged.
- `ib_out[N_CH]` out axi4s_dp_rdy_t: per-channel `tready`.
- `ob_out` out axi4s_dp_bus_t: merged stream toward the prefix core.
- `ob_in` in axi4s_dp_rdy_t: downstream `tready`.
- `ch_en` in N_CH: channel enable, sampled only at grant decision.
- `cur_ch` out $clog2(N_CH): currently granted channel, valid while `busy`.
- `busy` out 1: a frame is granted.
- `frame_stb` out N_CH: one-cycle pulse per accepted `tlast`, for stats.
- `wdog_err` out N_CH: sticky watchdog error per channel.
- `wdog_clr` in N_CH: write-1-to-clear pulses for `wdog_err`.
- `arb_int` out 1: registered OR of `wdog_err`.

## Operation
- FSM has two states, IDLE and GRANT.
- **IDLE:**
  - Search channels starting at `rr_ptr`, wrapping modulo `N_CH`, for the first channel with `ch_en` set and `tvalid` set.
  - On a hit, register `cur_ch`, clear `beat_cnt`, and go to GRANT on the next cycle. No data moves in IDLE.
- **GRANT:**
  - `ib_out[cur_ch].tready = (fifo_cnt < 2)`; every other `tready` is 0.
  - An accepted beat is written into the skid FIFO.
  - An accepted beat with `tlast` does three things: pulses `frame_stb[cur_ch]`, sets `rr_ptr = (cur_ch+1) mod N_CH`, and returns the FSM to IDLE.
- Deasserting `ch_en` mid-frame has no effect; the frame runs to `tlast`.
- **Skid FIFO:**
  - 2 entries, registered.
  - `ob_out` is the head entry, and `ob_out.tvalid = (fifo_cnt != 0)`.
  - Pop on `ob_out.tvalid & ob_in.tready`; push and pop can occur in the same cycle.
  - No combinational path from `ob_in` to any `ib_out`.
- **beat_cnt:** 16 bits, increments per accepted beat without `tlast`, saturates at `MAX_BEATS`.
- **Watchdog** (only when compiled in):
  - When an accepted non-`tlast` beat makes `beat_cnt == MAX_BEATS`, set `wdog_err[cur_ch]`.
  - Fires once per frame.
  - The frame continues and is not truncated.
- **wdog_err clear:** `wdog_err[i]` clears on `wdog_clr[i]`. If set and clear occur in the same cycle, set wins.
- **Reset values:** all outputs 0, `rr_ptr` 0, FSM in IDLE, FIFO empty, `beat_cnt` 0.
- **Reset mid-frame:** FIFO contents and the partial frame are discarded; no recovery is attempted.

## Timing
- Grant latency: 1 cycle from `tvalid` seen in IDLE to first `tready`.
- Frame gap: one idle cycle per frame boundary.
- Throughput within a frame: 1 beat/cycle while `ob_in.tready` stays high.
- Input-to-output latency: accepted beat appears on `ob_out` the next cycle when the FIFO was empty.
- `frame_stb`: asserted in the cycle after `tlast` acceptance (registered).
- `wdog_err`: set in the cycle after the triggering beat.
- `arb_int`: follows `wdog_err` by one further cycle.
- Backpressure: downstream stall of k cycles with a full FIFO gives `tready` low for exactly those cycles plus 0; FIFO count is the only coupling.

## Configuration
- `CR_PREFIX_IB_ARB_WDOG_EN` defined: watchdog logic and `beat_cnt` are present as described above.
- Undefined:
  - `beat_cnt` and watchdog logic are removed.
  - `wdog_err` and `arb_int` are tied to 0.
  - `wdog_clr` is ignored.
  - All other behaviour is identical.

## Test plan
- **Round-robin:** N_CH=4, all channels valid with 3-beat frames, rr_ptr=0 → grant order 0,1,2,3,0; each frame contiguous; one bubble between frames; four `frame_stb` pulses.
- **Skip disabled:** `ch_en=4'b1011` with all valid → channel 2 is never granted; order 0,1,3,0.
- **Backpressure:** `ob_in.tready` low for 5 cycles mid-frame → FIFO fills to 2; `ib_out[cur].tready` goes low; no beat lost or duplicated; order preserved after release.
- **Enable drop mid-frame:** channel 1 in GRANT, `ch_en[1]` drops at beat 2 of 6 → all 6 beats delivered, then arbitration continues from channel 2.
- **Watchdog:** MAX_BEATS=8, channel 3 sends a 12-beat frame → `wdog_err[3]` set after beat 8, `arb_int` one cycle later, all 12 beats delivered. Then `wdog_clr[3]` → both clear. Simultaneous set and clear → error stays set.
- **Reset mid-frame:** assert `rst_n` low during beat 3 → all outputs 0 immediately; after release, channel 0 is searched first.

Source files
------------

// File: rtl/cr_prefix_ib_arb_if.sv
// cr_prefix_ib_arb_pkg / cr_prefix_ib_arb_if
//   Beat types and the stream bundle used by the prefix ingress arbiter.
//   axi4s_dp_bus_t : one AXI4-stream beat (tvalid/tlast plus payload).
//   axi4s_dp_rdy_t : the matching tready.
//   Interface signals:
//     ib_in[N_CH]  per-channel input beats     (master -> slave)
//     ib_out[N_CH] per-channel tready          (slave -> master)
//     ob_out       merged beat toward the core (slave -> master)
//     ob_in        downstream tready           (master -> slave)
//   The arbiter connects through the slave modport; the traffic side uses master.

package cr_prefix_ib_arb_pkg;
   typedef struct packed {
      logic        tvalid;
      logic        tlast;
      logic [31:0] tdata;
      logic [3:0]  tkeep;
      logic [3:0]  tuser;
   } axi4s_dp_bus_t;

   typedef struct packed {
      logic tready;
   } axi4s_dp_rdy_t;
endpackage

interface cr_prefix_ib_arb_if
   import cr_prefix_ib_arb_pkg::*;
#(
   parameter int N_CH = 4
);
   axi4s_dp_bus_t ib_in  [N_CH];
   axi4s_dp_rdy_t ib_out [N_CH];
   axi4s_dp_bus_t ob_out;
   axi4s_dp_rdy_t ob_in;

   modport master (output ib_in, ob_in, input ib_out, ob_out);
   modport slave  (input ib_in, ob_in, output ib_out, ob_out);
endinterface

// File: rtl/cr_prefix_ib_arb.sv
// cr_prefix_ib_arb
//   N-channel frame-level round-robin ingress arbiter for the prefix datapath.
//   A grant is held until tlast so frames never interleave. Accepted beats go
//   through a 2-entry registered skid FIFO, so the input treadys depend only on
//   the FIFO count and never on the downstream tready.
//
//   Optional frame-length watchdog: define CR_PREFIX_IB_ARB_WDOG_EN to build it.
//   Without it, wdog_err/arb_int are tied low and wdog_clr is ignored.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          stream bundle (slave modport): ib_in/ib_out per channel,
//                  ob_out/ob_in merged output
//     ch_en        channel enables, looked at only when choosing a grant
//     cur_ch       granted channel (meaningful while busy)
//     busy         a frame is currently granted
//     frame_stb    one-cycle pulse per accepted tlast, per channel
//     wdog_err     sticky per-channel watchdog error
//     wdog_clr     write-1-to-clear for wdog_err (a same-cycle set wins)
//     arb_int      registered OR of wdog_err

module cr_prefix_ib_arb
   import cr_prefix_ib_arb_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int MAX_BEATS = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   cr_prefix_ib_arb_if.slave        bus,
   input  logic [N_CH-1:0]          ch_en,
   output logic [$clog2(N_CH)-1:0]  cur_ch,
   output logic                     busy,
   output logic [N_CH-1:0]          frame_stb,
   output logic [N_CH-1:0]          wdog_err,
   input  logic [N_CH-1:0]          wdog_clr,
   output logic                     arb_int
);

   localparam int CW = $clog2(N_CH);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state;
   logic [CW-1:0]  rr_ptr;

   // skid FIFO
   axi4s_dp_bus_t  mem [2];
   logic           wr_ptr;
   logic           rd_ptr;
   logic [1:0]     fifo_cnt;

   logic           space;
   logic           acc;
   logic           pop;
   axi4s_dp_bus_t  sel;

   // round-robin search
   logic           hit;
   logic [CW-1:0]  hit_ch;
   logic [CW:0]    idx;

   assign busy  = (state == GRANT);
   assign sel   = bus.ib_in[cur_ch];
   // Space depends only on the registered count: no ob_in -> ib_out path.
   assign space = (fifo_cnt < 2'd2);
   assign acc   = busy && space && sel.tvalid;
   assign pop   = (fifo_cnt != 2'd0) && bus.ob_in.tready;

   // First enabled and valid channel at or after rr_ptr, wrapping.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      idx    = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = {1'b0, rr_ptr} + (CW+1)'(k);
         if (idx >= (CW+1)'(N_CH))
            idx = idx - (CW+1)'(N_CH);
         if (!hit && ch_en[idx[CW-1:0]] && bus.ib_in[idx[CW-1:0]].tvalid) begin
            hit    = 1'b1;
            hit_ch = idx[CW-1:0];
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_rdy
      assign bus.ib_out[i] = '{tready: busy && space && (cur_ch == CW'(i))};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_ch    <= '0;
         rr_ptr    <= '0;
         frame_stb <= '0;
      end else begin
         frame_stb <= '0;
         case (state)
            IDLE: begin
               if (hit) begin
                  cur_ch <= hit_ch;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if (acc && sel.tlast) begin
                  frame_stb[cur_ch] <= 1'b1;
                  rr_ptr <= (cur_ch == CW'(N_CH-1)) ? '0 : cur_ch + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (acc) begin
            mem[wr_ptr] <= sel;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, acc} - {1'b0, pop};
      end
   end

   always_comb begin
      bus.ob_out        = mem[rd_ptr];
      bus.ob_out.tvalid = (fifo_cnt != 2'd0);
   end

`ifdef CR_PREFIX_IB_ARB_WDOG_EN
   logic [15:0]     beat_cnt;
   logic [N_CH-1:0] wdog_set;

   // beat_cnt saturates at MAX_BEATS, so the step onto it happens once per frame.
   always_comb begin
      wdog_set = '0;
      if (acc && !sel.tlast && beat_cnt == 16'(MAX_BEATS - 1))
         wdog_set[cur_ch] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         wdog_err <= '0;
         arb_int  <= 1'b0;
      end else begin
         if (state == IDLE && hit)
            beat_cnt <= '0;
         else if (acc && !sel.tlast && beat_cnt != 16'(MAX_BEATS))
            beat_cnt <= beat_cnt + 16'd1;
         wdog_err <= (wdog_err & ~wdog_clr) | wdog_set;
         arb_int  <= |wdog_err;
      end
   end
`else
   logic unused_wdog_clr;

   assign unused_wdog_clr = ^wdog_clr;
   assign wdog_err        = '0;
   assign arb_int         = 1'b0;
`endif

endmodule

// File: tb/tb_cr_prefix_ib_arb.sv
// tb_cr_prefix_ib_arb
//   Random traffic on four sources against a transaction-level model: the
//   model tracks the granted channel, the round-robin pointer, the queue of
//   beats held between input and output, and the watchdog counter, and every
//   cycle the DUT outputs are compared with what the model predicts.
//   Traffic phases: full throughput / channel 2 disabled / random enables and
//   heavy clears / bursty downstream stalls. Two resets are dropped mid-run.

module tb_cr_prefix_ib_arb;
   import cr_prefix_ib_arb_pkg::*;

   localparam int N    = 4;
   localparam int MAXB = 8;
   localparam int CYC  = 20000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  ch_en = '1;
   logic [N-1:0]  wdog_clr = '0;
   logic [1:0]    cur_ch;
   logic          busy;
   logic [N-1:0]  frame_stb;
   logic [N-1:0]  wdog_err;
   logic          arb_int;

   cr_prefix_ib_arb_if #(.N_CH(N)) bus ();

   cr_prefix_ib_arb #(.N_CH(N), .MAX_BEATS(MAXB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .ch_en     (ch_en),
      .cur_ch    (cur_ch),
      .busy      (busy),
      .frame_stb (frame_stb),
      .wdog_err  (wdog_err),
      .wdog_clr  (wdog_clr),
      .arb_int   (arb_int)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // sources
   bit            s_act [N];
   bit            s_vld [N];
   bit            s_acc [N];
   int            s_len [N];
   int            s_beat[N];
   int            s_fno [N];
   axi4s_dp_bus_t s_cur [N];
   int            stall = 0;

   // reference model
   bit            m_busy;
   int            m_ch, m_ptr, m_cnt;
   axi4s_dp_bus_t m_q[$];
   logic [N-1:0]  m_stb, m_err;
   logic          m_int;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [N-1:0] rdy_vec();
      logic [N-1:0] r;
      for (int c = 0; c < N; c++) r[c] = bus.ib_out[c].tready;
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
      m_q.delete();
      m_stb = '0; m_err = '0; m_int = 1'b0;
      for (int c = 0; c < N; c++) begin
         s_act[c] = 0; s_vld[c] = 0; s_acc[c] = 0;
         bus.ib_in[c] = '0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},   64'(busy), 64'd0);
      chk({tag, "_cur"},    64'(cur_ch), 64'd0);
      chk({tag, "_stb"},    64'(frame_stb), 64'd0);
      chk({tag, "_err"},    64'(wdog_err), 64'd0);
      chk({tag, "_int"},    64'(arb_int), 64'd0);
      chk({tag, "_ob"},     64'(bus.ob_out), 64'd0);
      chk({tag, "_tready"}, 64'(rdy_vec()), 64'd0);
   endtask

   task automatic check_outputs();
      logic [N-1:0] exp_rdy;
      exp_rdy = (m_busy && m_q.size() < 2) ? N'(1) << m_ch : '0;
      chk("tready", 64'(rdy_vec()), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_busy));
      if (m_busy) chk("cur_ch", 64'(cur_ch), 64'(m_ch));
      chk("ob_vld", 64'(bus.ob_out.tvalid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("ob_beat", 64'(bus.ob_out), 64'(m_q[0]));
      chk("frame_stb", 64'(frame_stb), 64'(m_stb));
      chk("wdog_err", 64'(wdog_err), 64'(m_err));
      chk("arb_int", 64'(arb_int), 64'(m_int));
   endtask

   // Advance the model across the coming clock edge using the stable inputs.
   task automatic step_model();
      axi4s_dp_bus_t b;
      bit            acc, pop;
      logic [N-1:0]  set;
      int            j;
      b   = bus.ib_in[m_ch];
      acc = m_busy && m_q.size() < 2 && b.tvalid;
      pop = m_q.size() != 0 && bus.ob_in.tready;
      for (int c = 0; c < N; c++)
         s_acc[c] = bus.ib_in[c].tvalid && bus.ib_out[c].tready;
      set = '0;
      if (acc && !b.tlast && m_cnt < MAXB) begin
         m_cnt++;
         if (m_cnt == MAXB) set[m_ch] = 1'b1;
      end
`ifdef CR_PREFIX_IB_ARB_WDOG_EN
      m_int = |m_err;
      m_err = (m_err & ~wdog_clr) | set;
`endif
      m_stb = (acc && b.tlast) ? N'(1) << m_ch : '0;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(b);
      if (m_busy) begin
         if (acc && b.tlast) begin
            m_busy = 0;
            m_ptr  = (m_ch + 1) % N;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!m_busy && ch_en[j] && bus.ib_in[j].tvalid) begin
               m_busy = 1; m_ch = j; m_cnt = 0;
            end
         end
      end
   endtask

   task automatic drive_inputs(input int cyc);
      int ph;
      ph = (cyc / 1000) % 4;
      for (int c = 0; c < N; c++) begin
         if (s_acc[c]) begin
            s_vld[c] = 0;
            if (s_beat[c] == s_len[c] - 1) s_act[c] = 0;
            else s_beat[c]++;
         end
         s_acc[c] = 0;
         if (!s_act[c] && $urandom_range(99) < 30) begin
            s_act[c] = 1; s_len[c] = $urandom_range(1, 12); s_beat[c] = 0; s_fno[c]++;
         end
         if (s_act[c] && !s_vld[c] && $urandom_range(99) < 80) begin
            s_vld[c] = 1;
            s_cur[c].tvalid = 1'b1;
            s_cur[c].tlast  = (s_beat[c] == s_len[c] - 1);
            s_cur[c].tdata  = {4'(c), 12'(s_fno[c]), 16'(s_beat[c])};
            s_cur[c].tkeep  = 4'($urandom);
            s_cur[c].tuser  = 4'($urandom);
         end
         bus.ib_in[c] = s_vld[c] ? s_cur[c] : '0;
      end
      case (ph)
         0: ch_en = 4'b1111;
         1: ch_en = 4'b1011;
         2: for (int c = 0; c < N; c++) if ($urandom_range(99) < 10) ch_en[c] = ~ch_en[c];
         default: ch_en = 4'b1111;
      endcase
      if (ph == 3) begin
         if (stall == 0 && $urandom_range(99) < 10) stall = $urandom_range(1, 8);
         bus.ob_in.tready = (stall == 0);
         if (stall > 0) stall--;
      end else begin
         bus.ob_in.tready = (ph == 0) ? 1'b1 : ($urandom_range(99) < (ph == 1 ? 90 : 60));
      end
      for (int c = 0; c < N; c++)
         wdog_clr[c] = ($urandom_range(99) < (ph == 2 ? 30 : 3));
   endtask

   initial begin
      bus.ob_in = '{tready: 1'b1};
      for (int c = 0; c < N; c++) s_fno[c] = 0;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_zero("rst");
      #1 rst_n = 1'b1;
      for (int cyc = 0; cyc < CYC; cyc++) begin
         @(negedge clk);
         check_outputs();
         step_model();
         @(posedge clk);
         #1;
         if (cyc == 7003 || cyc == 14007) begin
            rst_n = 1'b0;
            #1 chk_zero("rst_mid");
            model_reset();
            drive_inputs(cyc);
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
         end else begin
            drive_inputs(cyc);
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
